alu_arbiter_2req: RTL
=====================

# alu_arbiter_2req

Two-requester arbiter and sequencer for the shared 8-bit ALU (`alu_top_8bit`). Each requester submits one operation (A, B, sel) over a valid/ready handshake. The block grants the ALU round-robin, holds the operands in registers for a configurable number of execution cycles, and returns the registered result over a per-requester valid/ready response channel. Only one operation is in flight at a time.

## Interface
- EXEC_CYCLES, 1, cycles the operand registers drive the ALU before the result is captured; legal range 1..15.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_a, req0_b  in  8  requester 0 operands.
- req0_sel  in  3  requester 0 ALU op: 000 add, 001 sub, 010 and, 011 or, 100 shl, 101 sra.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as above, for requester 1.
- rsp0_valid  out  1  a result for requester 0 is available.
- rsp0_ready  in  1  requester 0 consumes its result.
- rsp0_y  out  8  result value.
- rsp0_cout  out  1  ALU carry-out.
- rsp0_err  out  1  sel was 110 or 111.
- rsp1_valid, rsp1_ready, rsp1_y, rsp1_cout, rsp1_err  same as above, for requester 1.
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  1  index of the last accepted requester.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- Round-robin pointer `rr`:
  - Reset value 0, meaning requester 0 has priority.
  - When both valids are high, `rr` selects the winner.
  - When only one valid is high, that requester wins regardless of `rr`.
- IDLE:
  - req_k_ready = (state==IDLE) && winner==k && req_k_valid. The loser's ready stays 0.
  - Acceptance happens when valid && ready at a clock edge.
  - On acceptance: latch a, b, sel into operand registers; grant_id <= k; counter <= EXEC_CYCLES-1; go to EXEC.
- EXEC:
  - The ALU is driven only from the operand registers.
  - Each cycle, decrement the counter.
  - When the counter is 0:
    - Capture Y and Cout into the result registers.
    - err <= (sel[2:1]==2'b11). For these encodings Y=0 and Cout=0, matching the ALU default.
    - rr <= ~grant_id.
    - Go to RESP.
- RESP:
  - rsp_k_valid = (state==RESP) && grant_id==k. The other channel's valid stays 0.
  - On rsp_k_ready, return to IDLE.
  - No new request is accepted while in EXEC or RESP. Both req_ready outputs are 0.
- Result routing:
  - rsp0_y/rsp1_y, rsp0_cout/rsp1_cout and rsp0_err/rsp1_err are driven from a single set of shared result registers.
  - Result values are meaningful only while the matching valid is high.
- A lone active requester is served back-to-back. The pointer still toggles, but it has no effect when only one valid is high.
- Requesters must hold a, b and sel stable while valid && !ready. The block samples them only on the acceptance edge.

## Timing
- Reset (asynchronous assert):
  - State returns to IDLE.
  - rr=0, grant_id=0, counter=0.
  - Result and err registers are cleared to 0.
  - All ready, valid, busy, y, cout and err outputs read 0.
  - Any in-flight operation is dropped and no response is issued.
- Acceptance is at edge t0. Result registers and rsp_valid become valid after edge t0+EXEC_CYCLES.
- With rsp_ready held high, the state returns to IDLE after edge t0+EXEC_CYCLES+1. The next acceptance is at the earliest at edge t0+EXEC_CYCLES+2, so throughput is one operation per EXEC_CYCLES+2 cycles.
- While rsp_valid is high, rsp_y, rsp_cout and rsp_err are stable. Backpressure of any length is legal.
- A requester may raise valid during EXEC or RESP. Its ready stays 0 until IDLE, and arbitration uses `rr` as it stands in that cycle.
- req_ready is combinational from req_valid and state, in the same cycle. No combinational path exists from rsp_ready to any req_ready.

## Test plan
- Reset: assert rst mid-cycle with both valids high → all outputs 0 immediately. After release, req0_ready=1 and req1_ready=0.
- Single add, EXEC_CYCLES=1: req0 with A=0xF0, B=0x20, sel=000 → rsp0_valid high 1 cycle after acceptance, rsp0_y=0x10, rsp0_cout=1, rsp0_err=0, rsp1_valid=0.
- Arithmetic shift: req1 with A=0x90, B=0x02, sel=101 → rsp1_y=0xE4, cout=0. Then A=0x81, B=0x01, sel=100 → rsp1_y=0x02.
- Contention: both valids held high for 4 operations with rsp_ready=1 → grant order 0,1,0,1. Accepts are spaced EXEC_CYCLES+2 cycles apart, and each response carries its own requester's result.
- Backpressure: hold rsp0_ready=0 for 5 cycles → rsp0_valid and rsp0_y stay stable, req1_ready stays 0, busy=1. Releasing rsp0_ready returns to IDLE and req1 is granted next.
- Error and reset mid-op: sel=110 → y=0x00, cout=0, err=1. Then, with EXEC_CYCLES=4, assert rst during EXEC → no rsp_valid ever rises for that operation, and rr=0 after release.

Source files
------------

// File: rtl/alu_arbiter_2req.sv
// alu_arbiter_2req: round-robin arbiter and sequencer sharing one 8-bit ALU between two requesters
module alu_arbiter_2req #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_y,
    output logic       rsp0_cout,
    output logic       rsp0_err,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_y,
    output logic       rsp1_cout,
    output logic       rsp1_err,
    output logic       busy,
    output logic       grant_id
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     state;
    logic       rr;
    logic [3:0] cnt;
    logic [7:0] op_a, op_b, res_y, alu_y;
    logic [2:0] op_sel;
    logic       res_cout, res_err, alu_cout, winner;
    logic [8:0] sum, diff;
    // rr only breaks ties; a lone valid always wins
    assign winner     = (req0_valid && req1_valid) ? rr : req1_valid;
    // ready is masked by rst so nothing looks accepted while reset is held
    assign req0_ready = !rst && state == IDLE && !winner && req0_valid;
    assign req1_ready = !rst && state == IDLE && winner && req1_valid;
    assign busy       = state != IDLE;
    assign rsp0_valid = state == RESP && !grant_id;
    assign rsp1_valid = state == RESP && grant_id;
    assign rsp0_y     = res_y;
    assign rsp1_y     = res_y;
    assign rsp0_cout  = res_cout;
    assign rsp1_cout  = res_cout;
    assign rsp0_err   = res_err;
    assign rsp1_err   = res_err;
    assign sum        = {1'b0, op_a} + {1'b0, op_b};
    assign diff       = {1'b0, op_a} + {1'b0, ~op_b} + 9'd1;
    // shared ALU fed only from the operand registers; cout is carry for add, no-borrow for sub
    always_comb begin
        alu_y    = 8'h00;
        alu_cout = 1'b0;
        case (op_sel)
            3'b000:  {alu_cout, alu_y} = sum;
            3'b001:  {alu_cout, alu_y} = diff;
            3'b010:  alu_y = op_a & op_b;
            3'b011:  alu_y = op_a | op_b;
            3'b100:  alu_y = op_a << op_b[2:0];
            3'b101:  alu_y = $signed(op_a) >>> op_b[2:0];
            default: alu_y = 8'h00;
        endcase
    end
    // IDLE accepts one op, EXEC counts down then captures the result, RESP waits for the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            grant_id <= 1'b0;
            cnt      <= 4'd0;
            op_a     <= 8'h00;
            op_b     <= 8'h00;
            op_sel   <= 3'b000;
            res_y    <= 8'h00;
            res_cout <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    op_a     <= req1_ready ? req1_a : req0_a;
                    op_b     <= req1_ready ? req1_b : req0_b;
                    op_sel   <= req1_ready ? req1_sel : req0_sel;
                    grant_id <= req1_ready;
                    cnt      <= 4'(EXEC_CYCLES - 1);
                    state    <= EXEC;
                end
                EXEC: if (cnt == 4'd0) begin
                    res_y    <= alu_y;
                    res_cout <= alu_cout;
                    res_err  <= &op_sel[2:1];
                    rr       <= ~grant_id;
                    state    <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (grant_id ? rsp1_ready : rsp0_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
